// File: rtl/switch_nport.sv
// switch_nport: N-port packet switch with one FIFO and one round-robin arbiter per output.
//
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready      per-input handshake
//   in_src_addr/in_dst_addr  flattened input addresses, port i at [i*ADDR_W +: ADDR_W]
//   in_data                  flattened input payload, port i at [i*DATA_W +: DATA_W]
//   out_valid / out_ready    per-output handshake
//   out_src_addr/out_dst_addr/out_data  head packet of each output FIFO (0 when empty)
//   drop_count               (only with SWITCH_NPORT_DROP_CNT_EN) saturating count of
//                            accepted out-of-window packets
//
// Optional feature macro: SWITCH_NPORT_DROP_CNT_EN
module switch_nport #(
   parameter int unsigned       NUM_PORTS  = 4,
   parameter int unsigned       ADDR_W     = 8,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       FIFO_DEPTH = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 8'h10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        in_valid,
   output logic [NUM_PORTS-1:0]        in_ready,
   input  logic [NUM_PORTS*ADDR_W-1:0] in_src_addr,
   input  logic [NUM_PORTS*ADDR_W-1:0] in_dst_addr,
   input  logic [NUM_PORTS*DATA_W-1:0] in_data,
   output logic [NUM_PORTS-1:0]        out_valid,
   input  logic [NUM_PORTS-1:0]        out_ready,
   output logic [NUM_PORTS*ADDR_W-1:0] out_src_addr,
   output logic [NUM_PORTS*ADDR_W-1:0] out_dst_addr,
   output logic [NUM_PORTS*DATA_W-1:0] out_data
`ifdef SWITCH_NPORT_DROP_CNT_EN
   ,
   output logic [15:0]                 drop_count
`endif
);

   localparam int unsigned S  = $clog2(NUM_PORTS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = 2 * ADDR_W + DATA_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   // Packed entry layout: {src, dst, data}
   logic [EW-1:0]        in_pkt   [NUM_PORTS];
   logic [S-1:0]         sel      [NUM_PORTS];
   logic [NUM_PORTS-1:0] in_win;

   logic [S-1:0]         rr_q     [NUM_PORTS];
   logic [PW-1:0]        wr_q     [NUM_PORTS];
   logic [PW-1:0]        rd_q     [NUM_PORTS];
   logic [CW-1:0]        cnt_q    [NUM_PORTS];
   logic [EW-1:0]        mem      [NUM_PORTS][FIFO_DEPTH];

   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] grant_vld;
   logic [S-1:0]         grant_idx [NUM_PORTS];
   logic [EW-1:0]        push_pkt  [NUM_PORTS];
   logic [S-1:0]         idx;
   logic [EW-1:0]        head;

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         in_pkt[i] = {in_src_addr[i*ADDR_W +: ADDR_W], in_dst_addr[i*ADDR_W +: ADDR_W],
                      in_data[i*DATA_W +: DATA_W]};
         sel[i]    = in_dst_addr[i*ADDR_W +: S];
         in_win[i] = in_dst_addr[i*ADDR_W + S +: ADDR_W - S] == BASE_ADDR[ADDR_W-1:S];
      end
   end

   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         full[o]  = cnt_q[o] == FULL_CNT;
         empty[o] = cnt_q[o] == '0;
         pop[o]   = !empty[o] && out_ready[o];
      end
   end

   // Out-of-window inputs are always ready (dropped); in-window inputs only when granted.
   // Full is taken from registered occupancy, so a same-edge pop does not free a slot.
   always_comb begin
      in_ready  = ~in_win;
      grant_vld = '0;
      idx       = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         grant_idx[o] = '0;
         if (!full[o]) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
               idx = rr_q[o] + S'(k);  // wraps naturally: NUM_PORTS is a power of 2
               if (!grant_vld[o] && in_valid[idx] && in_win[idx] && sel[idx] == S'(o)) begin
                  grant_vld[o] = 1'b1;
                  grant_idx[o] = idx;
               end
            end
         end
         if (grant_vld[o]) in_ready[grant_idx[o]] = 1'b1;
         push_pkt[o] = in_pkt[grant_idx[o]];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            rr_q[o]  <= '0;
            wr_q[o]  <= '0;
            rd_q[o]  <= '0;
            cnt_q[o] <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (grant_vld[o]) begin
               wr_q[o] <= wr_q[o] + 1'b1;
               rr_q[o] <= grant_idx[o] + 1'b1;
            end
            if (pop[o]) rd_q[o] <= rd_q[o] + 1'b1;
            case ({grant_vld[o], pop[o]})
               2'b10:   cnt_q[o] <= cnt_q[o] + 1'b1;
               2'b01:   cnt_q[o] <= cnt_q[o] - 1'b1;
               default: cnt_q[o] <= cnt_q[o];
            endcase
         end
      end
   end

   // Storage needs no reset: contents are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (grant_vld[o]) mem[o][wr_q[o]] <= push_pkt[o];
      end
   end

   always_comb begin
      head = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         out_valid[o] = !empty[o];
         head         = empty[o] ? '0 : mem[o][rd_q[o]];
         out_src_addr[o*ADDR_W +: ADDR_W] = head[DATA_W + ADDR_W +: ADDR_W];
         out_dst_addr[o*ADDR_W +: ADDR_W] = head[DATA_W +: ADDR_W];
         out_data[o*DATA_W +: DATA_W]     = head[DATA_W-1:0];
      end
   end

`ifdef SWITCH_NPORT_DROP_CNT_EN
   logic [NUM_PORTS-1:0] drop;
   logic [16:0]          drop_sum;
   logic [15:0]          drop_cnt_q;

   always_comb begin
      drop     = in_valid & ~in_win;
      drop_sum = {1'b0, drop_cnt_q};
      for (int i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 17'(drop[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  drop_cnt_q <= '0;
      else if (drop_sum[16])      drop_cnt_q <= 16'hFFFF;
      else                        drop_cnt_q <= drop_sum[15:0];
   end

   assign drop_count = drop_cnt_q;
`endif

endmodule
